// File: rtl/twiddle_gen_pkg.sv
`default_nettype none
//==============================================================================
// Module   : twiddle_gen_pkg
// Purpose  : Shared FFT package: FSM states, quarter-wave depth, saturation
//            limit and the elaboration-time cosine quantiser for twiddle_gen.
// Revision : 1.0 - initial release
//==============================================================================
package twiddle_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam real C_TWO_PI = 6.283185307179586;

    function automatic int quarter_depth(input int log2_n);
        return 1 << (log2_n - 2);
    endfunction

    function automatic int sat_limit(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Taylor series; only ever called with 0 <= x <= pi/2
    function automatic real cos_first_quadrant(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / $itor((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic int twiddle_code(input int m, input int log2_n, input int width);
        real angle;
        real scaled;
        int  code;
        angle  = C_TWO_PI * $itor(m) / $itor(1 << log2_n);
        scaled = cos_first_quadrant(angle) * $itor(1 << (width - 1));
        code   = $rtoi(scaled + 0.5);
        if (code > sat_limit(width)) code = sat_limit(width);
        if (code < 0) code = 0;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_rom.sv
`default_nettype none
//==============================================================================
// Module   : twiddle_rom
// Purpose  : Dual-read quarter-wave cosine table (N/4+1 entries) with the
//            sign applied ahead of the registered read outputs.
// Revision : 1.0 - initial release
//==============================================================================
module twiddle_rom
    import twiddle_gen_pkg::*;
#(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int LOG2_N        = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [LOG2_N-2:0]        addr_a_i,
    input  logic [LOG2_N-2:0]        addr_b_i,
    input  logic                     neg_a_i,
    input  logic                     neg_b_i,
    output logic [TWIDDLE_WIDTH-1:0] data_a_o,
    output logic [TWIDDLE_WIDTH-1:0] data_b_o
);

    localparam int DEPTH = quarter_depth(LOG2_N);

    logic [TWIDDLE_WIDTH-1:0] rom_w [0:DEPTH];
    logic [TWIDDLE_WIDTH-1:0] mag_a, mag_b;
    logic [TWIDDLE_WIDTH-1:0] data_a_q, data_b_q;

    for (genvar m = 0; m <= DEPTH; m++) begin : g_rom
        localparam logic [TWIDDLE_WIDTH-1:0] C_CODE =
            TWIDDLE_WIDTH'(twiddle_code(m, LOG2_N, TWIDDLE_WIDTH));
        assign rom_w[m] = C_CODE;
    end

    assign mag_a = rom_w[addr_a_i];
    assign mag_b = rom_w[addr_b_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (en_i) begin
            data_a_q <= neg_a_i ? -mag_a : mag_a;
            data_b_q <= neg_b_i ? -mag_b : mag_b;
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
//==============================================================================
// Module   : twiddle_gen
// Purpose  : Radix-2 DIT twiddle sequencer: N/2 quantised twiddles per stage
//            with a 2-deep ready/valid pipeline.
// Options  : TWIDDLE_GEN_INVERSE_EN adds the 'inverse' port (conjugate output)
// Revision : 1.0 - initial release
//==============================================================================
module twiddle_gen
    import twiddle_gen_pkg::*;
#(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int LOG2_N        = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LOG2_N-1:0]        stage,
`ifdef TWIDDLE_GEN_INVERSE_EN
    input  logic                     inverse,
`endif
    input  logic                     out_ready,
    output logic [TWIDDLE_WIDTH-1:0] twdl_r,
    output logic [TWIDDLE_WIDTH-1:0] twdl_i,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err
);

    localparam int                AW          = LOG2_N - 1;
    localparam logic [AW-1:0]     QTR_A       = AW'(quarter_depth(LOG2_N));
    localparam logic [AW-1:0]     IDX_LAST    = '1;
    localparam logic [LOG2_N-1:0] STAGE_LIMIT = LOG2_N'(LOG2_N);
    localparam logic [LOG2_N-1:0] SHIFT_BASE  = LOG2_N'(LOG2_N - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [LOG2_N-1:0]   stage_q, shamt;
    logic [AW-1:0]       k;
    logic [AW-1:0]       addr_a_d, addr_b_d, addr_a_q, addr_b_q;
    logic                neg_a_d, neg_b_d, neg_a_q, neg_b_q, inv_neg;
    logic                v1_q, last1_q, v2_q, last2_q, err_q, err_d;
    logic                advance, accept, issue;

    assign advance = ~v2_q | out_ready;
    assign accept  = start & (stage < STAGE_LIMIT) & (state_q == ST_IDLE);
    assign issue   = (state_q == ST_RUN) & advance;
    assign err_d   = start & ((state_q != ST_IDLE) | (stage >= STAGE_LIMIT));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (idx_q == IDX_LAST) state_d = ST_DRAIN;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!v1_q && advance) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // (i mod 2^s) * 2^(L-1-s) is i shifted left, truncated to L-1 bits
    assign shamt = SHIFT_BASE - stage_q;
    assign k     = idx_q << shamt;

    // N/2 equals 2^AW, so N/2-k is the AW-bit two's-complement of k
    always_comb begin
        addr_a_d = k;
        neg_a_d  = 1'b0;
        addr_b_d = QTR_A - k;
        neg_b_d  = inv_neg;
        if (k > QTR_A) begin
            addr_a_d = '0 - k;
            neg_a_d  = 1'b1;
            addr_b_d = k - QTR_A;
        end
    end

`ifdef TWIDDLE_GEN_INVERSE_EN
    logic inv_q;
    always_ff @(posedge clk) begin
        if (rst)         inv_q <= 1'b0;
        else if (accept) inv_q <= inverse;
    end
    assign inv_neg = ~inv_q;
`else
    assign inv_neg = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            stage_q  <= '0;
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (accept) stage_q <= stage;
            if (advance) begin
                v1_q     <= issue;
                last1_q  <= issue & (idx_q == IDX_LAST);
                addr_a_q <= addr_a_d;
                addr_b_q <= addr_b_d;
                neg_a_q  <= neg_a_d;
                neg_b_q  <= neg_b_d;
                v2_q     <= v1_q;
                last2_q  <= last1_q;
            end
        end
    end

    twiddle_rom #(
        .TWIDDLE_WIDTH (TWIDDLE_WIDTH),
        .LOG2_N        (LOG2_N)
    ) u_rom (
        .clk      (clk),
        .rst      (rst),
        .en_i     (advance),
        .addr_a_i (addr_a_q),
        .addr_b_i (addr_b_q),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .data_a_o (twdl_r),
        .data_b_o (twdl_i)
    );

    assign out_valid = v2_q;
    assign out_last  = last2_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_twiddle_gen
// Purpose  : Self-checking bench for twiddle_gen (LOG2_N=6, TWIDDLE_WIDTH=10).
// Revision : 1.0 - initial release
//==============================================================================
module tb_twiddle_gen;

    localparam int  TW   = 10;
    localparam int  L    = 6;
    localparam int  N    = 64;
    localparam int  HALF = 32;
    localparam real PI   = 3.141592653589793;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [L-1:0]  stage;
    logic [TW-1:0] twdl_r, twdl_i;
    logic          out_valid, out_last, busy, err;

    always #5 clk = ~clk;

    twiddle_gen #(.TWIDDLE_WIDTH(TW), .LOG2_N(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
`ifdef TWIDDLE_GEN_INVERSE_EN
        .inverse   (1'b0),
`endif
        .out_ready (out_ready),
        .twdl_r    (twdl_r),
        .twdl_i    (twdl_i),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sr();
        return int'($signed(twdl_r));
    endfunction
    function automatic int si();
        return int'($signed(twdl_i));
    endfunction

    // Reference: round-half-away of x*2^(TW-1), magnitude capped at 2^(TW-1)-1
    function automatic int qnt(input real x);
        real a;
        int  m;
        a = (x < 0.0) ? -x : x;
        m = $rtoi(a * 512.0 + 0.5);
        if (m > 511) m = 511;
        return (x < 0.0) ? -m : m;
    endfunction
    function automatic real theta(input int s, input int i);
        int kk;
        kk = (i % (1 << s)) * (1 << (L - 1 - s));
        return 2.0 * PI * $itor(kk) / $itor(N);
    endfunction
    function automatic int model_r(input int s, input int i);
        return qnt($cos(theta(s, i)));
    endfunction
    function automatic int model_i(input int s, input int i);
        return -qnt($sin(theta(s, i)));
    endfunction

    int got_r [0:5][0:HALF-1];
    int got_i [0:5][0:HALF-1];
    int got_l [0:5][0:HALF-1];
    int got_n;
    int first_cyc;

    // Called just after a negedge; returns at a negedge with busy low
    task automatic run_stage(input int s, input bit rnd, input int poke, input int rst_at);
        int cyc = 0;
        bit done = 0;
        bit pv = 0, pr = 0;
        int p_r = 0, p_i = 0, p_l = 0;
        int extra;
        got_n = 0;
        first_cyc = -1;
        stage = L'(s);
        start = 1'b1;
        out_ready = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (poke != 0 && cyc == poke);
            if (poke != 0 && cyc == poke + 1) chk("err_busy_pulse", int'(err), 1);
            if (poke != 0 && cyc == poke + 2) chk("err_busy_clear", int'(err), 0);
            if (cyc == 1) chk("busy_after_start", int'(busy), 1);
            if (pv && !pr) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_r", sr(), p_r);
                chk("stall_i", si(), p_i);
                chk("stall_last", int'(out_last), p_l);
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (cyc > 1 && !busy) begin
                done = 1;
            end else if (rst_at >= 0 && out_valid && got_n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_mid_valid", int'(out_valid), 0);
                chk("rst_mid_busy", int'(busy), 0);
                chk("rst_mid_twdl_r", sr(), 0);
                rst = 1'b0;
                extra = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (out_valid) extra++;
                end
                chk("post_rst_no_valid", extra, 0);
                done = 1;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                pv = out_valid; pr = out_ready;
                p_r = sr(); p_i = si(); p_l = int'(out_last);
                if (out_valid && out_ready) begin
                    if (got_n < HALF) begin
                        got_r[s][got_n] = sr();
                        got_i[s][got_n] = si();
                        got_l[s][got_n] = int'(out_last);
                    end
                    got_n++;
                end
            end
        end
        out_ready = 1'b1;
        if (!done) chk("run_timeout", 0, 1);
    endtask

    task automatic verify(input int s, input string tag);
        chk({tag, "_count"}, got_n, HALF);
        chk({tag, "_latency"}, first_cyc, 3);
        for (int i = 0; i < HALF; i++) begin
            chk($sformatf("%s_r[%0d]", tag, i), got_r[s][i], model_r(s, i));
            chk($sformatf("%s_i[%0d]", tag, i), got_i[s][i], model_i(s, i));
            chk($sformatf("%s_last[%0d]", tag, i), got_l[s][i], (i == HALF - 1) ? 1 : 0);
        end
    endtask

    typedef struct {
        int stg;
        int idx;
        int er;
        int ei;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int vcount;
        int s;
        tbl[0] = '{0, 0, 511, 0};
        tbl[1] = '{0, 31, 511, 0};
        tbl[2] = '{1, 0, 511, 0};
        tbl[3] = '{1, 1, 0, -511};
        tbl[4] = '{1, 30, 511, 0};
        tbl[5] = '{1, 31, 0, -511};
        tbl[6] = '{5, 8, 362, -362};
        tbl[7] = '{5, 16, 0, -511};
        tbl[8] = '{5, 31, -510, -50};
        tbl[9] = '{5, 0, 511, 0};

        rst = 1'b1; start = 1'b0; stage = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_twdl_r", sr(), 0);
        chk("reset_twdl_i", si(), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_last", int'(out_last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        run_stage(0, 0, 0, -1); verify(0, "stage0");
        run_stage(1, 0, 0, -1); verify(1, "stage1");
        run_stage(5, 0, 0, -1); verify(5, "stage5");

        for (int t = 0; t < 10; t++) begin
            chk($sformatf("tbl%0d_r", t), got_r[tbl[t].stg][tbl[t].idx], tbl[t].er);
            chk($sformatf("tbl%0d_i", t), got_i[tbl[t].stg][tbl[t].idx], tbl[t].ei);
        end

        run_stage(5, 1, 0, -1); verify(5, "stage5_stall");
        run_stage(3, 0, 8, -1); verify(3, "busy_start");

        // Illegal stage from idle: error pulse, no sequence
        stage = L'(6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_stage_err", int'(err), 1);
        chk("bad_stage_busy", int'(busy), 0);
        @(negedge clk);
        chk("bad_stage_err_clear", int'(err), 0);
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy) vcount++;
        end
        chk("bad_stage_no_output", vcount, 0);

        run_stage(5, 0, 0, 10);
        chk("rst_mid_count", got_n, 10);
        run_stage(5, 0, 0, -1); verify(5, "after_rst");

        repeat (6) begin
            s = $urandom_range(0, 5);
            run_stage(s, 1, 0, -1);
            verify(s, $sformatf("rand_s%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
